// File: rtl/cmd_monitor_pkg.sv
// Shared types, command characters, canned replies and ASCII/hex helpers for the
// serial command monitor.
package cmd_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_REQ,
        ST_HALT_WAIT,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WAIT,
        ST_REPLY
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    localparam logic [7:0] CMD_HALT   = 8'h68;  // 'h'
    localparam logic [7:0] CMD_GO     = 8'h67;  // 'g'
    localparam logic [7:0] CMD_STATUS = 8'h73;  // 's'
    localparam logic [7:0] CMD_READ   = 8'h72;  // 'r'
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;

    // data[0] is transmitted first
    typedef struct packed {
        logic [2:0][7:0] data;
        logic [1:0]      len;
    } reply_t;

    localparam reply_t RPL_OK = '{data: {CH_LF, 8'h4B, 8'h4F}, len: 2'd3};
    localparam reply_t RPL_TO = '{data: {CH_LF, 8'h4F, 8'h54}, len: 2'd3};
    localparam reply_t RPL_H  = '{data: {8'h00, CH_LF, 8'h48}, len: 2'd2};
    localparam reply_t RPL_R  = '{data: {8'h00, CH_LF, 8'h52}, len: 2'd2};
    localparam reply_t RPL_E  = '{data: {8'h00, CH_LF, 8'h45}, len: 2'd2};
    localparam reply_t RPL_Q  = '{data: {8'h00, CH_LF, 8'h3F}, len: 2'd2};

    // Returns {valid, nibble}; accepts 0-9, a-f, A-F.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        return 5'b0;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/cmd_reply_tx.sv
// Reply transmitter: holds up to three reply bytes and hands them one at a time
// to the UART transmitter, stepping only on tick-enabled edges.
module cmd_reply_tx
    import cmd_monitor_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            tick,
    input  logic            load,
    input  logic [2:0][7:0] reply_data,
    input  logic [1:0]      reply_len,
    input  logic            send_strobe,
    output logic [7:0]      send_data,
    output logic            data_avail,
    output logic            done,
    output tx_state_t       tx_state
);

    // Handshake: send_data and data_avail rise together and hold until a rising
    // edge of send_strobe is seen on a tick; data_avail then stays low for one
    // full tick before the next byte is presented.
    logic [2:0][7:0] buf_q;
    logic [1:0]      len_q;
    logic [1:0]      idx;
    logic            send_prev;
    logic            send_edge;

    assign send_edge = tick & send_strobe & ~send_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            send_prev  <= 1'b0;
            send_data  <= '0;
            data_avail <= 1'b0;
            done       <= 1'b0;
            tx_state   <= TX_IDLE;
        end else if (tick) begin
            send_prev <= send_strobe;
            done      <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (load) begin
                        buf_q      <= reply_data;
                        len_q      <= reply_len;
                        idx        <= 2'd0;
                        send_data  <= reply_data[0];
                        data_avail <= 1'b1;
                        tx_state   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (send_edge) begin
                        data_avail <= 1'b0;
                        if (idx == len_q - 2'd1) begin
                            done     <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            idx      <= idx + 2'd1;
                            tx_state <= TX_GAP;
                        end
                    end
                end
                TX_GAP: begin
                    send_data  <= buf_q[idx];
                    data_avail <= 1'b1;
                    tx_state   <= TX_SEND;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_monitor.sv
// Serial command monitor: decodes single-letter commands, halts/releases the Z80
// through BUSRQ/BUSAK and reads memory bytes while the CPU is halted.
module cmd_monitor
    import cmd_monitor_pkg::*;
#(
    parameter int DIV_BITS      = 8,
    parameter int ADDR_W        = 16,
    parameter int BUSAK_TIMEOUT = 255,
    parameter int MEM_WAIT      = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        receive_data,
    input  logic              recv_strobe,
    output logic [7:0]        send_data,
    input  logic              send_strobe,
    output logic              data_avail,
    output logic              busrq_n,
    input  logic              busak_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_n,
    input  logic [7:0]        mem_data,
    output logic              halted,
    output state_t            dbg_state,
    output tx_state_t         dbg_tx_state
);

    localparam int NDIG  = ADDR_W / 4;
    localparam int DIG_W = $clog2(NDIG + 1);
    localparam int TO_W  = $clog2(BUSAK_TIMEOUT + 1);
    localparam int WT_W  = $clog2(MEM_WAIT + 1);

    logic [DIV_BITS-1:0] div_cnt;
    logic                tick;
    logic                recv_prev;
    logic                recv_edge;
    state_t              state;
    logic [TO_W-1:0]     to_cnt;
    logic [WT_W-1:0]     wait_cnt;
    logic [DIG_W-1:0]    digit_cnt;
    logic [ADDR_W-1:0]   addr_sr;
    logic [4:0]          nib;
    reply_t              rpl;
    logic                tx_load;
    logic                tx_done;

    assign tick      = &div_cnt;
    assign recv_edge = tick & recv_strobe & ~recv_prev;
    assign nib       = ascii_to_nibble(receive_data);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            recv_prev <= 1'b0;
            state     <= ST_IDLE;
            to_cnt    <= '0;
            wait_cnt  <= '0;
            digit_cnt <= '0;
            addr_sr   <= '0;
            rpl       <= '0;
            tx_load   <= 1'b0;
            busrq_n   <= 1'b1;
            mem_addr  <= '0;
            mem_rd_n  <= 1'b1;
            halted    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_BITS'(1);
            if (tick) begin
                recv_prev <= recv_strobe;
                halted    <= ~busrq_n & ~busak_n;
                tx_load   <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (recv_edge) begin
                            case (receive_data)
                                CMD_HALT: state <= ST_HALT_REQ;
                                CMD_GO: begin
                                    busrq_n <= 1'b1;
                                    rpl     <= RPL_OK;
                                    tx_load <= 1'b1;
                                    state   <= ST_REPLY;
                                end
                                CMD_STATUS: begin
                                    rpl     <= halted ? RPL_H : RPL_R;
                                    tx_load <= 1'b1;
                                    state   <= ST_REPLY;
                                end
                                CMD_READ: begin
                                    if (halted) begin
                                        addr_sr   <= '0;
                                        digit_cnt <= '0;
                                        state     <= ST_ADDR;
                                    end else begin
                                        rpl     <= RPL_E;
                                        tx_load <= 1'b1;
                                        state   <= ST_REPLY;
                                    end
                                end
                                CH_LF, CH_CR: ;
                                default: begin
                                    rpl     <= RPL_Q;
                                    tx_load <= 1'b1;
                                    state   <= ST_REPLY;
                                end
                            endcase
                        end
                    end
                    ST_HALT_REQ: begin
                        busrq_n <= 1'b0;
                        to_cnt  <= '0;
                        state   <= ST_HALT_WAIT;
                    end
                    ST_HALT_WAIT: begin
                        // The counter reaches BUSAK_TIMEOUT on the same edge busrq_n is released.
                        if (!busak_n) begin
                            rpl     <= RPL_OK;
                            tx_load <= 1'b1;
                            state   <= ST_REPLY;
                        end else if (to_cnt == TO_W'(BUSAK_TIMEOUT - 1)) begin
                            to_cnt  <= TO_W'(BUSAK_TIMEOUT);
                            busrq_n <= 1'b1;
                            rpl     <= RPL_TO;
                            tx_load <= 1'b1;
                            state   <= ST_REPLY;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    ST_ADDR: begin
                        if (recv_edge) begin
                            if (nib[4]) begin
                                addr_sr <= (addr_sr << 4) | ADDR_W'(nib[3:0]);
                                if (digit_cnt == DIG_W'(NDIG - 1)) state <= ST_MEM_RD;
                                else digit_cnt <= digit_cnt + DIG_W'(1);
                            end else begin
                                addr_sr <= '0;
                                rpl     <= RPL_Q;
                                tx_load <= 1'b1;
                                state   <= ST_REPLY;
                            end
                        end
                    end
                    ST_MEM_RD: begin
                        mem_addr <= addr_sr;
                        mem_rd_n <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_MEM_WAIT;
                    end
                    ST_MEM_WAIT: begin
                        if (wait_cnt == WT_W'(MEM_WAIT - 1)) begin
                            mem_rd_n <= 1'b1;
                            rpl      <= '{data: {CH_LF, nibble_to_ascii(mem_data[3:0]),
                                                 nibble_to_ascii(mem_data[7:4])},
                                          len: 2'd3};
                            tx_load  <= 1'b1;
                            state    <= ST_REPLY;
                        end else begin
                            wait_cnt <= wait_cnt + WT_W'(1);
                        end
                    end
                    ST_REPLY: begin
                        if (tx_done) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    cmd_reply_tx u_tx (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .load       (tx_load),
        .reply_data (rpl.data),
        .reply_len  (rpl.len),
        .send_strobe(send_strobe),
        .send_data  (send_data),
        .data_avail (data_avail),
        .done       (tx_done),
        .tx_state   (dbg_tx_state)
    );

endmodule
